// File: rtl/dds_ctrl_pkg.sv
// Shared DDS control definitions: data width, mode encodings, sweep FSM states.
// Contents:
//   DW              - width of every DDS word and configuration register
//   mode_e          - mode[1:0] encodings (3 is not listed and behaves as direct)
//   state_e         - sweep controller states
//   mode_is_sweep() - true for the single and continuous sweep modes
package dds_ctrl_pkg;

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_CONT   = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DIRECT = 3'd2,
        SWEEP  = 3'd3,
        HOLD   = 3'd4
    } state_e;

    function automatic logic mode_is_sweep(input logic [1:0] sel);
        return (sel == MODE_SINGLE) || (sel == MODE_CONT);
    endfunction

endpackage

// File: rtl/drg_sweep_ctrl_if.sv
// Configuration / DDS output bundle of the sweep controller.
// master: configuration side (drives param_wen, mode, direct words, ramp
//         start/end/step per channel; receives fword/pword/amp, strobes, busy)
// slave : the sweep controller itself.
interface drg_sweep_ctrl_if;
    import dds_ctrl_pkg::*;

    logic          param_wen;
    logic [DW-1:0] mode;
    logic [DW-1:0] direct_fword;
    logic [DW-1:0] direct_pword;
    logic [DW-1:0] direct_amp;
    logic [DW-1:0] drg_f_start;
    logic [DW-1:0] drg_f_end;
    logic [DW-1:0] drg_f_step;
    logic [DW-1:0] drg_p_start;
    logic [DW-1:0] drg_p_end;
    logic [DW-1:0] drg_p_step;
    logic [DW-1:0] drg_a_start;
    logic [DW-1:0] drg_a_end;
    logic [DW-1:0] drg_a_step;
    logic [DW-1:0] fword;
    logic [DW-1:0] pword;
    logic [DW-1:0] amp;
    logic          dds_upd;
    logic          sweep_done;
    logic          busy;

    modport master (
        output param_wen, mode, direct_fword, direct_pword, direct_amp,
               drg_f_start, drg_f_end, drg_f_step,
               drg_p_start, drg_p_end, drg_p_step,
               drg_a_start, drg_a_end, drg_a_step,
        input  fword, pword, amp, dds_upd, sweep_done, busy
    );

    modport slave (
        input  param_wen, mode, direct_fword, direct_pword, direct_amp,
               drg_f_start, drg_f_end, drg_f_step,
               drg_p_start, drg_p_end, drg_p_step,
               drg_a_start, drg_a_end, drg_a_step,
        output fword, pword, amp, dds_upd, sweep_done, busy
    );

endinterface

// File: rtl/drg_channel.sv
// One ramp channel: start/end/step shadow registers, current value register,
// saturating 33-bit step and done flags.
// Ports:
//   clk, rstn     - clock, synchronous active-low reset
//   load_i        - capture start/end/step shadows, cur <= start_i
//   step_i        - advance cur by one step unless already done
//   reload_i      - cur <= shadowed start (continuous sweep restart)
//   start_i/end_i/step_val_i - live ramp configuration
//   cur_d_c       - value cur takes at the next edge
//   done_c        - channel is done with its current value
//   nxt_done_c    - channel will be done after this edge (non-load edges)
//   ld_done_c     - channel would be done right after a load of the live inputs
module drg_channel import dds_ctrl_pkg::*; (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load_i,
    input  logic          step_i,
    input  logic          reload_i,
    input  logic [DW-1:0] start_i,
    input  logic [DW-1:0] end_i,
    input  logic [DW-1:0] step_val_i,
    output logic [DW-1:0] cur_d_c,
    output logic          done_c,
    output logic          nxt_done_c,
    output logic          ld_done_c
);

    logic [DW-1:0] start_q;
    logic [DW-1:0] end_q;
    logic [DW-1:0] step_q;
    logic [DW-1:0] cur_q;
    logic [DW-1:0] cur_d;
    logic [DW:0]   sum_c;

    assign done_c     = (step_q == '0) || (cur_q >= end_q);
    assign nxt_done_c = (step_q == '0) || (cur_d >= end_q);
    assign ld_done_c  = (step_val_i == '0) || (start_i >= end_i);
    assign cur_d_c    = cur_d;

    // Next value: the carry bit makes the end-clamp cover overflow as well.
    always_comb begin
        sum_c = {1'b0, cur_q} + {1'b0, step_q};
        cur_d = cur_q;
        if (load_i) begin
            cur_d = start_i;
        end else if (reload_i) begin
            cur_d = start_q;
        end else if (step_i && !done_c) begin
            if (sum_c[DW] || (sum_c[DW-1:0] >= end_q)) begin
                cur_d = end_q;
            end else begin
                cur_d = sum_c[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            start_q <= '0;
            end_q   <= '0;
            step_q  <= '0;
            cur_q   <= '0;
        end else begin
            if (load_i) begin
                start_q <= start_i;
                end_q   <= end_i;
                step_q  <= step_val_i;
            end
            cur_q <= cur_d;
        end
    end

endmodule

// File: rtl/drg_sweep_ctrl.sv
// DDS digital-ramp sweep controller: direct/single/continuous sweep of the
// frequency, phase and amplitude words with a programmable dwell per step.
// Ports:
//   clk, rstn - clock, synchronous active-low reset
//   bus       - drg_sweep_ctrl_if.slave (config in, DDS words + strobes out)
// Parameter DWELL_CYCLES: clocks between sweep steps (1 .. 2^32-1).
module drg_sweep_ctrl import dds_ctrl_pkg::*; #(
    parameter int unsigned DWELL_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            rstn,
    drg_sweep_ctrl_if.slave bus
);

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    state_e        state_q;
    logic          wen_q;
    logic          cont_q;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] fword_q;
    logic [DW-1:0] pword_q;
    logic [DW-1:0] amp_q;
    logic          dds_upd_q;
    logic          sweep_done_q;
    logic          busy_q;

    logic          tc_c;
    logic          sweep_tc_c;
    logic [2:0]    done_c;
    logic [2:0]    nxt_done_c;
    logic [2:0]    ld_done_c;
    logic          all_done_c;
    logic          all_nxt_done_c;
    logic          all_ld_done_c;
    logic [DW-1:0] f_cur_d;
    logic [DW-1:0] p_cur_d;
    logic [DW-1:0] a_cur_d;
    logic          mode_unused_c;

    assign mode_unused_c  = ^bus.mode[DW-1:2];
    assign tc_c           = (dwell_q == DWELL_LAST);
    // A new param_wen aborts the step that would otherwise happen on this edge.
    assign sweep_tc_c     = (state_q == SWEEP) && tc_c && !bus.param_wen;
    assign all_done_c     = &done_c;
    assign all_nxt_done_c = &nxt_done_c;
    assign all_ld_done_c  = &ld_done_c;

    drg_channel u_ch_f (
        .clk(clk), .rstn(rstn),
        .load_i(wen_q), .step_i(sweep_tc_c && !all_done_c), .reload_i(sweep_tc_c && all_done_c),
        .start_i(bus.drg_f_start), .end_i(bus.drg_f_end), .step_val_i(bus.drg_f_step),
        .cur_d_c(f_cur_d), .done_c(done_c[0]), .nxt_done_c(nxt_done_c[0]), .ld_done_c(ld_done_c[0])
    );

    drg_channel u_ch_p (
        .clk(clk), .rstn(rstn),
        .load_i(wen_q), .step_i(sweep_tc_c && !all_done_c), .reload_i(sweep_tc_c && all_done_c),
        .start_i(bus.drg_p_start), .end_i(bus.drg_p_end), .step_val_i(bus.drg_p_step),
        .cur_d_c(p_cur_d), .done_c(done_c[1]), .nxt_done_c(nxt_done_c[1]), .ld_done_c(ld_done_c[1])
    );

    drg_channel u_ch_a (
        .clk(clk), .rstn(rstn),
        .load_i(wen_q), .step_i(sweep_tc_c && !all_done_c), .reload_i(sweep_tc_c && all_done_c),
        .start_i(bus.drg_a_start), .end_i(bus.drg_a_end), .step_val_i(bus.drg_a_step),
        .cur_d_c(a_cur_d), .done_c(done_c[2]), .nxt_done_c(nxt_done_c[2]), .ld_done_c(ld_done_c[2])
    );

    // Controller FSM; state LOAD always coincides with wen_q being set.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            wen_q        <= 1'b0;
            cont_q       <= 1'b0;
            dwell_q      <= '0;
            fword_q      <= '0;
            pword_q      <= '0;
            amp_q        <= '0;
            dds_upd_q    <= 1'b0;
            sweep_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            wen_q        <= bus.param_wen;
            dds_upd_q    <= 1'b0;
            sweep_done_q <= 1'b0;
            if (wen_q) begin
                // LOAD always completes; a param_wen seen now queues another LOAD.
                dwell_q   <= '0;
                dds_upd_q <= 1'b1;
                cont_q    <= (bus.mode[1:0] == MODE_CONT);
                if (mode_is_sweep(bus.mode[1:0])) begin
                    fword_q      <= f_cur_d;
                    pword_q      <= p_cur_d;
                    amp_q        <= a_cur_d;
                    sweep_done_q <= all_ld_done_c;
                    if (bus.param_wen) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end else if (all_ld_done_c) begin
                        state_q <= HOLD;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= SWEEP;
                        busy_q  <= 1'b1;
                    end
                end else begin
                    fword_q <= bus.direct_fword;
                    pword_q <= bus.direct_pword;
                    amp_q   <= bus.direct_amp;
                    state_q <= bus.param_wen ? LOAD : DIRECT;
                    busy_q  <= bus.param_wen;
                end
            end else if (bus.param_wen) begin
                state_q <= LOAD;
                busy_q  <= 1'b1;
                dwell_q <= '0;
            end else if (state_q == SWEEP) begin
                if (tc_c) begin
                    dwell_q   <= '0;
                    dds_upd_q <= 1'b1;
                    fword_q   <= f_cur_d;
                    pword_q   <= p_cur_d;
                    amp_q     <= a_cur_d;
                    // End of a pass: only after a real step, not after a reload.
                    if (!all_done_c && all_nxt_done_c) begin
                        sweep_done_q <= 1'b1;
                        if (!cont_q) begin
                            state_q <= HOLD;
                            busy_q  <= 1'b0;
                        end
                    end
                end else begin
                    dwell_q <= dwell_q + DW'(1);
                end
            end
        end
    end

    assign bus.fword      = fword_q;
    assign bus.pword      = pword_q;
    assign bus.amp        = amp_q;
    assign bus.dds_upd    = dds_upd_q;
    assign bus.sweep_done = sweep_done_q;
    assign bus.busy       = busy_q;

endmodule
